// File: rtl/multicycle_cu.sv
// Multicycle control FSM for the 16-bit RISC-V-style core, with a memory wait handshake, an optional wait timeout and illegal-instruction detection.
// Define CU_PERF_COUNTERS_EN to build the retired-instruction and stall-cycle counters.
module multicycle_cu #(
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned MAX_WAIT = 0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               zero_flag,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_wr,
    output logic               ir_wr,
    output logic               reg_wr,
    output logic [1:0]         result_src,
    output logic [2:0]         alu_control,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         imm_src,
    output logic [3:0]         state_o,
    output logic               illegal_instr,
    output logic               bus_error,
    output logic [CNT_W-1:0]   instr_retired,
    output logic [CNT_W-1:0]   stall_cycles
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADR   = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE_R = 4'd6,
        ALU_WB    = 4'd7,
        EXECUTE_I = 4'd8,
        BRANCH    = 4'd9
    } state_t;

    localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    state_t              state, state_next;
    logic [1:0]          op;
    logic [2:0]          funct3;
    logic                is_load, is_store, is_rtype, is_itype, is_beqz, is_bnez;
    logic                mem_wait, timeout;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                unused_instr_bits;

    assign op                = instruction[1:0];
    assign funct3            = instruction[INSTR_W-1 -: 3];
    assign unused_instr_bits = ^instruction[INSTR_W-4:2];
    assign state_o           = state;

    assign is_load  = (op == 2'b00) && (funct3 == 3'b000);
    assign is_store = (op == 2'b00) && (funct3 == 3'b001);
    assign is_rtype = (op == 2'b01);
    assign is_itype = (op == 2'b10);
    assign is_beqz  = (op == 2'b11) && (funct3 == 3'b000);
    assign is_bnez  = (op == 2'b11) && (funct3 == 3'b001);

    assign mem_wait = ((state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE)) && !mem_ready;
    // wait_cnt holds the wait cycles already spent, so this fires on the MAX_WAIT-th one
    assign timeout  = (MAX_WAIT != 0) && mem_wait && (wait_cnt == WAIT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= ((MAX_WAIT != 0) && mem_wait && !timeout) ? wait_cnt + WAIT_W'(1) : '0;
        end
    end

    always_comb begin
        state_next    = state;
        pc_write      = 1'b0;
        adr_src       = 1'b0;
        mem_wr        = 1'b0;
        ir_wr         = 1'b0;
        reg_wr        = 1'b0;
        result_src    = 2'b00;
        alu_control   = 3'b000;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        imm_src       = 2'b00;
        illegal_instr = 1'b0;
        bus_error     = 1'b0;
        case (state)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_wr      = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_next = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                if (op == 2'b11)   imm_src = 2'b10;
                else if (is_store) imm_src = 2'b01;
                if (is_load || is_store)      state_next = MEM_ADR;
                else if (is_rtype)            state_next = EXECUTE_R;
                else if (is_itype)            state_next = EXECUTE_I;
                else if (is_beqz || is_bnez)  state_next = BRANCH;
                else begin
                    illegal_instr = 1'b1;
                    state_next    = FETCH;
                end
            end
            MEM_ADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                imm_src    = is_store ? 2'b01 : 2'b00;
                state_next = is_store ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                adr_src = 1'b1;
                if (mem_ready) state_next = MEM_WB;
            end
            MEM_WB: begin
                result_src = 2'b01;
                reg_wr     = 1'b1;
                state_next = FETCH;
            end
            MEM_WRITE: begin
                adr_src = 1'b1;
                mem_wr  = 1'b1;
                if (mem_ready) state_next = FETCH;
            end
            EXECUTE_R: begin
                alu_src_a   = 2'b10;
                alu_control = funct3;
                state_next  = ALU_WB;
            end
            EXECUTE_I: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = funct3;
                state_next  = ALU_WB;
            end
            ALU_WB: begin
                reg_wr     = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b11;
                alu_control = 3'b001;
                pc_write    = (is_beqz && zero_flag) || (is_bnez && !zero_flag);
                state_next  = FETCH;
            end
            default: state_next = FETCH;
        endcase
        if (timeout) begin
            bus_error  = 1'b1;
            state_next = FETCH;
            pc_write   = 1'b0;
            ir_wr      = 1'b0;
            reg_wr     = 1'b0;
        end
        // write strobes must be quiet for the whole reset pulse, not just after the edge
        if (!rst_n) begin
            pc_write      = 1'b0;
            ir_wr         = 1'b0;
            mem_wr        = 1'b0;
            reg_wr        = 1'b0;
            illegal_instr = 1'b0;
            bus_error     = 1'b0;
        end
    end

`ifdef CU_PERF_COUNTERS_EN
    logic             retire;
    logic [CNT_W-1:0] retired_q, stall_q;

    assign retire = (state == MEM_WB) || (state == ALU_WB) || (state == BRANCH) ||
                    ((state == MEM_WRITE) && mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (retire)   retired_q <= retired_q + CNT_W'(1);
            if (mem_wait) stall_q   <= stall_q + CNT_W'(1);
        end
    end

    assign instr_retired = retired_q;
    assign stall_cycles  = stall_q;
`else
    assign instr_retired = '0;
    assign stall_cycles  = '0;
`endif

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed self-checking bench for multicycle_cu with MAX_WAIT=4 and CNT_W=4.
module tb_multicycle_cu;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned CNT_W   = 4;
`ifdef CU_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic [INSTR_W-1:0] instruction;
    logic               zero_flag;
    logic               mem_ready;
    logic               pc_write, adr_src, mem_wr, ir_wr, reg_wr;
    logic [1:0]         result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]         alu_control;
    logic [3:0]         state_o;
    logic               illegal_instr, bus_error;
    logic [CNT_W-1:0]   instr_retired, stall_cycles;

    int checks = 0;
    int errors = 0;

    multicycle_cu #(
        .INSTR_W  (INSTR_W),
        .MAX_WAIT (4),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instruction   (instruction),
        .zero_flag     (zero_flag),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_wr        (mem_wr),
        .ir_wr         (ir_wr),
        .reg_wr        (reg_wr),
        .result_src    (result_src),
        .alu_control   (alu_control),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .imm_src       (imm_src),
        .state_o       (state_o),
        .illegal_instr (illegal_instr),
        .bus_error     (bus_error),
        .instr_retired (instr_retired),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [INSTR_W-1:0] mk(input logic [2:0] f3, input logic [1:0] opc);
        return {f3, 11'b0, opc};
    endfunction

    // counters read as zero unless the perf option is built in
    function automatic logic [31:0] cexp(input int n);
        logic [CNT_W-1:0] v;
        v = PERF ? CNT_W'(n) : '0;
        return 32'(v);
    endfunction

    initial begin
        rst_n       = 1'b0;
        instruction = '0;
        zero_flag   = 1'b0;
        mem_ready   = 1'b1;
        tick();
        tick();
        check("rst_state", state_o, 0);
        check("rst_pc_write", pc_write, 0);
        check("rst_ir_wr", ir_wr, 0);
        check("rst_retired", instr_retired, cexp(0));
        check("rst_stall", stall_cycles, cexp(0));

        rst_n = 1'b1;
        #1;
        check("fetch_ir_wr", ir_wr, 1);
        check("fetch_pc_write", pc_write, 1);
        check("fetch_src_b", alu_src_b, 2'b10);
        check("fetch_result_src", result_src, 2'b10);

        // LOAD: 0,1,2,3,4,0
        instruction = mk(3'b000, 2'b00);
        tick(); check("ld_state1", state_o, 1); check("ld_dec_reg_wr", reg_wr, 0);
        check("ld_dec_src_a", alu_src_a, 2'b01);
        tick(); check("ld_state2", state_o, 2); check("ld_adr_src_a", alu_src_a, 2'b10);
        check("ld_adr_imm", imm_src, 2'b00);
        tick(); check("ld_state3", state_o, 3); check("ld_rd_adr_src", adr_src, 1);
        check("ld_rd_reg_wr", reg_wr, 0);
        tick(); check("ld_state4", state_o, 4); check("ld_wb_reg_wr", reg_wr, 1);
        check("ld_wb_result_src", result_src, 2'b01);
        tick(); check("ld_state0", state_o, 0); check("ld_end_reg_wr", reg_wr, 0);
        check("ld_retired", instr_retired, cexp(1));
        check("ld_stall", stall_cycles, cexp(0));

        // three FETCH wait cycles, ready on the fourth
        mem_ready = 1'b0;
        #1;
        check("fw_ir_wr", ir_wr, 0);
        check("fw_pc_write", pc_write, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fw_state", state_o, 0);
            check("fw_hold_ir_wr", ir_wr, 0);
        end
        mem_ready = 1'b1;
        #1;
        check("fw_ready_ir_wr", ir_wr, 1);
        check("fw_ready_pc_write", pc_write, 1);
        check("fw_no_bus_error", bus_error, 0);
        check("fw_stall", stall_cycles, cexp(3));

        // BNEZ, zero_flag=0: taken
        instruction = mk(3'b001, 2'b11);
        tick(); check("bnez_dec_imm", imm_src, 2'b10);
        tick(); check("bnez_state", state_o, 9); check("bnez_pc_write", pc_write, 1);
        check("bnez_alu", alu_control, 3'b001); check("bnez_src_b", alu_src_b, 2'b11);
        tick(); check("bnez_ret", state_o, 0);

        // BEQZ, zero_flag=0 not taken, then zero_flag=1 taken
        instruction = mk(3'b000, 2'b11);
        tick();
        tick(); check("beqz_state", state_o, 9); check("beqz_nt_pc_write", pc_write, 0);
        zero_flag = 1'b1;
        #1;
        check("beqz_t_pc_write", pc_write, 1);
        zero_flag = 1'b0;
        tick(); check("beqz_ret", state_o, 0);

        // R-type funct3=101
        instruction = mk(3'b101, 2'b01);
        tick();
        tick(); check("r_state", state_o, 6); check("r_alu", alu_control, 3'b101);
        check("r_src_b", alu_src_b, 2'b00);
        tick(); check("r_wb_state", state_o, 7); check("r_wb_reg_wr", reg_wr, 1);
        check("r_wb_result_src", result_src, 2'b00);
        tick(); check("r_ret", state_o, 0);

        // I-type funct3=011
        instruction = mk(3'b011, 2'b10);
        tick();
        tick(); check("i_state", state_o, 8); check("i_alu", alu_control, 3'b011);
        check("i_src_b", alu_src_b, 2'b01);
        tick(); check("i_wb_state", state_o, 7);
        tick(); check("i_ret", state_o, 0);

        // STORE with immediate ready
        instruction = mk(3'b001, 2'b00);
        tick();
        tick(); check("st_adr_imm", imm_src, 2'b01);
        tick(); check("st_state", state_o, 5); check("st_mem_wr", mem_wr, 1);
        check("st_adr_src", adr_src, 1);
        tick(); check("st_ret", state_o, 0); check("st_end_mem_wr", mem_wr, 0);

        // STORE with memory never ready: timeout on the 4th wait cycle
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("to_mem_wr", mem_wr, 1);
            check("to_early_bus_error", bus_error, 0);
            tick();
        end
        check("to_state5", state_o, 5);
        check("to_last_mem_wr", mem_wr, 1);
        check("to_bus_error", bus_error, 1);
        check("to_reg_wr", reg_wr, 0);
        check("to_pc_write", pc_write, 0);
        tick();
        check("to_ret_state", state_o, 0);
        check("to_bus_error_clr", bus_error, 0);
        check("to_ret_ir_wr", ir_wr, 0);
        mem_ready = 1'b1;
        #1;

        // illegal encodings
        instruction = mk(3'b111, 2'b11);
        tick(); check("ill_state", state_o, 1); check("ill_flag", illegal_instr, 1);
        check("ill_reg_wr", reg_wr, 0); check("ill_pc_write", pc_write, 0);
        tick(); check("ill_ret", state_o, 0); check("ill_clr", illegal_instr, 0);
        instruction = mk(3'b010, 2'b00);
        tick(); check("ill2_flag", illegal_instr, 1);
        tick(); check("ill2_ret", state_o, 0);

        // reset asserted while in MEM_WRITE
        instruction = mk(3'b001, 2'b00);
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        check("rmw_state", state_o, 5);
        check("rmw_mem_wr", mem_wr, 1);
        rst_n = 1'b0;
        #1;
        check("rmw_rst_mem_wr", mem_wr, 0);
        check("rmw_rst_state", state_o, 0);
        check("rmw_rst_retired", instr_retired, cexp(0));
        check("rmw_rst_stall", stall_cycles, cexp(0));
        mem_ready = 1'b1;
        tick();
        check("rmw_hold_pc_write", pc_write, 0);
        check("rmw_hold_ir_wr", ir_wr, 0);
        rst_n = 1'b1;
        #1;

        // 17 R-type instructions wrap the 4-bit retired counter to 1
        instruction = mk(3'b000, 2'b01);
        for (int i = 0; i < 17 * 4; i++) tick();
        check("cnt_state", state_o, 0);
        check("cnt_retired", instr_retired, cexp(17));
        mem_ready = 1'b0;
        tick();
        tick();
        mem_ready = 1'b1;
        #1;
        check("cnt_stall", stall_cycles, cexp(2));
        check("cnt_stall_state", state_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
